// File: rtl/dac80504_spi_model.sv
// Behavioural DAC80504 model: oversamples SPI/LDAC pins on clk and decodes 24-bit frames into four DAC codes.
// Latency: 3 clk from a pin edge to its effect; no backpressure, the SPI master is never stalled.
module dac80504_spi_model #(
    parameter logic [15:0] DEVICE_ID = 16'h2150
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csn,
    input  logic        sclk,
    input  logic        sdi,
    input  logic        ldacn,
    output logic        sdo,
    output logic [15:0] vout0,
    output logic [15:0] vout1,
    output logic [15:0] vout2,
    output logic [15:0] vout3
);
    logic [1:0] csn_meta, sclk_meta, sdi_meta, ldacn_meta;
    logic       csn_q, sclk_q, ldacn_q;

    logic [23:0] shift_q;
    logic [4:0]  bit_cnt;
    logic        in_frame;

    logic [15:0]       sync_q, config_q, gain_q;
    logic [3:0][15:0]  buf_q, vout_q;
    logic [15:0]       sync_n, config_n, gain_n;
    logic [3:0][15:0]  buf_n, vout_n;

    logic [23:0] rd_word, sdo_sr;
    logic        rd_pend, sdo_act;
    logic        rd_ld, ldac_evt, soft_rst;
    logic [15:0] rd_data;

    // csn pipeline resets low so a reset inside a frame never fakes a csn falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csn_meta   <= 2'b00;
            sclk_meta  <= 2'b00;
            sdi_meta   <= 2'b00;
            ldacn_meta <= 2'b11;
            csn_q      <= 1'b0;
            sclk_q     <= 1'b0;
            ldacn_q    <= 1'b1;
        end else begin
            csn_meta   <= {csn_meta[0], csn};
            sclk_meta  <= {sclk_meta[0], sclk};
            sdi_meta   <= {sdi_meta[0], sdi};
            ldacn_meta <= {ldacn_meta[0], ldacn};
            csn_q      <= csn_meta[1];
            sclk_q     <= sclk_meta[1];
            ldacn_q    <= ldacn_meta[1];
        end
    end

    logic csn_fall, csn_rise, sclk_fall, sclk_rise, ldac_rise, commit;
    logic        frm_rw;
    logic [3:0]  frm_addr;
    logic [15:0] frm_data;

    assign csn_fall  =  csn_q & ~csn_meta[1];
    assign csn_rise  = ~csn_q &  csn_meta[1];
    assign sclk_fall =  sclk_q & ~sclk_meta[1];
    assign sclk_rise = ~sclk_q &  sclk_meta[1];
    assign ldac_rise = ~ldacn_q & ldacn_meta[1];
    assign commit    = csn_rise & in_frame & (bit_cnt >= 5'd24);
    assign frm_rw    = shift_q[23];
    assign frm_addr  = shift_q[19:16];
    assign frm_data  = shift_q[15:0];

    // Commit is resolved before the LDAC transfer so a coincident ldacn edge sees the new buffer.
    always_comb begin
        sync_n   = sync_q;
        config_n = config_q;
        gain_n   = gain_q;
        buf_n    = buf_q;
        vout_n   = vout_q;
        ldac_evt = ldac_rise;
        soft_rst = 1'b0;
        rd_ld    = 1'b0;
        rd_data  = 16'h0000;
        if (commit && frm_rw) begin
            rd_ld = 1'b1;
            case (frm_addr)
                4'd1:                      rd_data = DEVICE_ID;
                4'd2:                      rd_data = sync_q;
                4'd3:                      rd_data = config_q;
                4'd4:                      rd_data = gain_q;
                4'd8, 4'd9, 4'd10, 4'd11:  rd_data = buf_q[frm_addr[1:0]];
                default:                   rd_data = 16'h0000;
            endcase
        end else if (commit) begin
            case (frm_addr)
                4'd2: sync_n   = frm_data;
                4'd3: config_n = frm_data;
                4'd4: gain_n   = frm_data;
                4'd5: begin
                    soft_rst = (frm_data[3:0] == 4'b1010);
                    if (frm_data[4]) ldac_evt = 1'b1;
                end
                4'd6: begin
                    for (int n = 0; n < 4; n++) begin
                        if (sync_q[8+n]) begin
                            buf_n[n] = frm_data;
                            if (!sync_q[n]) vout_n[n] = frm_data;
                        end
                    end
                end
                4'd8, 4'd9, 4'd10, 4'd11: begin
                    buf_n[frm_addr[1:0]] = frm_data;
                    if (!sync_q[frm_addr[1:0]]) vout_n[frm_addr[1:0]] = frm_data;
                end
                default: ;
            endcase
        end
        if (soft_rst) begin
            sync_n   = 16'h0000;
            config_n = 16'h0000;
            gain_n   = 16'h0000;
            buf_n    = '0;
            vout_n   = '0;
        end
        if (ldac_evt) begin
            for (int n = 0; n < 4; n++) begin
                if (sync_n[n]) vout_n[n] = buf_n[n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= 24'h0;
            bit_cnt  <= 5'd0;
            in_frame <= 1'b0;
            sync_q   <= 16'h0;
            config_q <= 16'h0;
            gain_q   <= 16'h0;
            buf_q    <= '0;
            vout_q   <= '0;
            rd_word  <= 24'h0;
            rd_pend  <= 1'b0;
            sdo_sr   <= 24'h0;
            sdo_act  <= 1'b0;
        end else begin
            sync_q   <= sync_n;
            config_q <= config_n;
            gain_q   <= gain_n;
            buf_q    <= buf_n;
            vout_q   <= vout_n;
            if (csn_fall) begin
                in_frame <= 1'b1;
                bit_cnt  <= 5'd0;
                if (rd_pend) begin
                    sdo_sr  <= rd_word;
                    sdo_act <= 1'b1;
                    rd_pend <= 1'b0;
                end
            end else if (csn_rise) begin
                in_frame <= 1'b0;
                sdo_act  <= 1'b0;
            end else if (in_frame) begin
                if (sclk_fall) begin
                    shift_q <= {shift_q[22:0], sdi_meta[1]};
                    if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
                end
                // The MSB is presented from csn fall, so the first sclk rise must not advance it.
                if (sclk_rise && bit_cnt != 5'd0) sdo_sr <= {sdo_sr[22:0], 1'b0};
            end
            if (rd_ld) begin
                rd_word <= {1'b1, 3'b000, frm_addr, rd_data};
                rd_pend <= 1'b1;
            end
        end
    end

    assign sdo   = ~csn & sdo_act & sdo_sr[23];
    assign vout0 = vout_q[0];
    assign vout1 = vout_q[1];
    assign vout2 = vout_q[2];
    assign vout3 = vout_q[3];
endmodule

// File: tb/tb_dac80504_spi_model.sv
// Directed-vector bench for dac80504_spi_model: SPI frames with hand-computed DAC codes and readback words.
module tb_dac80504_spi_model;
    logic        clk = 1'b0;
    logic        rst_n, csn, sclk, sdi, ldacn;
    logic        sdo;
    logic [15:0] vout0, vout1, vout2, vout3;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [23:0] rx;

    dac80504_spi_model #(.DEVICE_ID(16'h2150)) dut (
        .clk(clk), .rst_n(rst_n), .csn(csn), .sclk(sclk), .sdi(sdi), .ldacn(ldacn),
        .sdo(sdo), .vout0(vout0), .vout1(vout1), .vout2(vout2), .vout3(vout3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends bits w[nbits-1:0] MSB first; sdo is captured just before each sclk fall.
    task automatic send_bits(input logic [31:0] w, input int nbits, output logic [23:0] r);
        r = 24'h0;
        for (int i = nbits - 1; i >= 0; i--) begin
            sdi  = w[i];
            sclk = 1'b1;
            wait_clk(4);
            r    = {r[22:0], sdo};
            sclk = 1'b0;
            wait_clk(4);
        end
    endtask

    task automatic frame_open();
        csn = 1'b0;
        wait_clk(4);
    endtask

    task automatic frame_close();
        csn = 1'b1;
        wait_clk(4);
    endtask

    task automatic frame(input logic [31:0] w, input int nbits, output logic [23:0] r);
        frame_open();
        send_bits(w, nbits, r);
        frame_close();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; csn = 1'b1; sclk = 1'b0; sdi = 1'b0; ldacn = 1'b1;
        wait_clk(3);
        chk("rst_vout0", {16'h0, vout0}, 32'h0);
        chk("rst_vout1", {16'h0, vout1}, 32'h0);
        chk("rst_vout2", {16'h0, vout2}, 32'h0);
        chk("rst_vout3", {16'h0, vout3}, 32'h0);
        chk("rst_sdo", {31'h0, sdo}, 32'h0);
        rst_n = 1'b1;
        wait_clk(4);

        // Async write to channel 0 with channels 1..3 synchronous
        frame(32'h0002000E, 24, rx);
        frame_open();
        send_bits(32'h0008BEEF, 24, rx);
        chk("async_before_csn", {16'h0, vout0}, 32'h0);
        frame_close();
        chk("async_vout0", {16'h0, vout0}, 32'h0000BEEF);

        // Sync write to channel 2, held until ldacn rises
        ldacn = 1'b0;
        wait_clk(4);
        frame(32'h000ACAFE, 24, rx);
        wait_clk(4);
        chk("sync_hold_vout2", {16'h0, vout2}, 32'h0);
        ldacn = 1'b1;
        wait_clk(4);
        chk("sync_ldac_vout2", {16'h0, vout2}, 32'h0000CAFE);

        // 20-bit frame to addr 9 is discarded
        frame(32'h00091111 >> 4, 20, rx);
        chk("short_vout1", {16'h0, vout1}, 32'h0);
        frame(32'h00890000, 24, rx);
        frame(32'h00000000, 24, rx);
        chk("short_buf1_rb", {8'h0, rx}, 32'h00890000);

        // csn and ldacn rise together: LDAC sees the freshly written buffer
        ldacn = 1'b0;
        wait_clk(4);
        frame_open();
        send_bits(32'h000B5555, 24, rx);
        csn   = 1'b1;
        ldacn = 1'b1;
        wait_clk(4);
        chk("same_clk_vout3", {16'h0, vout3}, 32'h00005555);

        // Broadcast to all four channels, all asynchronous
        frame(32'h00020F00, 24, rx);
        frame(32'h00061234, 24, rx);
        chk("bcast_vout0", {16'h0, vout0}, 32'h00001234);
        chk("bcast_vout1", {16'h0, vout1}, 32'h00001234);
        chk("bcast_vout2", {16'h0, vout2}, 32'h00001234);
        chk("bcast_vout3", {16'h0, vout3}, 32'h00001234);

        // Readback of DEVICE_ID and SYNC
        frame(32'h00810000, 24, rx);
        chk("sdo_idle_csn_high", {31'h0, sdo}, 32'h0);
        frame(32'h00000000, 24, rx);
        chk("rb_device_id", {8'h0, rx}, 32'h00812150);
        frame(32'h00820000, 24, rx);
        frame(32'h00000000, 24, rx);
        chk("rb_sync", {8'h0, rx}, 32'h00820F00);

        // 28-bit frame: only the last 24 bits count
        frame(32'h0F08AAAA, 28, rx);
        chk("extra_bits_vout0", {16'h0, vout0}, 32'h0000AAAA);

        // Reset mid-frame, then keep clocking the aborted frame: it must be ignored
        frame_open();
        send_bits(32'h00000008, 12, rx);
        rst_n = 1'b0;
        wait_clk(2);
        chk("mid_rst_vout0", {16'h0, vout0}, 32'h0);
        chk("mid_rst_vout1", {16'h0, vout1}, 32'h0);
        chk("mid_rst_vout2", {16'h0, vout2}, 32'h0);
        chk("mid_rst_vout3", {16'h0, vout3}, 32'h0);
        rst_n = 1'b1;
        wait_clk(4);
        send_bits(32'h0008FFFF, 24, rx);
        frame_close();
        chk("aborted_frame_vout0", {16'h0, vout0}, 32'h0);
        frame(32'h00820000, 24, rx);
        frame(32'h00000000, 24, rx);
        chk("rst_sync_rb", {8'h0, rx}, 32'h00820000);
        frame(32'h0008ABCD, 24, rx);
        chk("post_rst_vout0", {16'h0, vout0}, 32'h0000ABCD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dac80504_spi_model.md
# dac80504_spi_model

Cycle-based behavioural model of a four-channel, 16-bit DAC80504 SPI DAC. It is clocked by the system clock and oversamples the SPI pins (`csn`, `sclk`, `sdi`) and `ldacn`. It decodes 24-bit frames into the device register map and presents the four DAC codes as parallel 16-bit outputs. It sits in simulation benches opposite the gradient/DAC SPI drivers, so driver timing and register sequencing can be checked against known output codes.

## Interface
- `DEVICE_ID`, default 16'h2150: read-only value returned at address 1.
- `clk`  in  1  system clock; must be at least 8× the `sclk` frequency.
- `rst_n`  in  1  asynchronous, active-low reset.
- `csn`  in  1  SPI chip select, active low.
- `sclk`  in  1  SPI clock.
- `sdi`  in  1  SPI data in, MSB first.
- `ldacn`  in  1  load-DAC strobe; its rising edge updates synchronous channels.
- `sdo`  out  1  SPI readback data.
- `vout0`..`vout3`  out  16 each  active DAC codes for channels 0–3.
- One clock; reset is asynchronous and active-low.

## Operation
- Input synchronisation
  - `csn`, `sclk`, `sdi` and `ldacn` each pass through a 2-FF synchroniser into the `clk` domain.
  - Edges are detected from the synchronised values.
- Frame format: {R/W (1 = read), 3 reserved bits, addr[3:0], data[15:0]}, 24 bits, MSB first.
- Shifting
  - While `csn` is low, `sdi` is shifted in on each detected `sclk` falling edge, and a bit counter increments, saturating at 31.
  - A `csn` falling edge clears the counter.
- Commit: on a `csn` rising edge with count ≥ 24, the last 24 bits shifted in are decoded. With count < 24 the frame is discarded and no register changes.
- Register map
  - 0 NOP.
  - 1 DEVICE_ID (read-only).
  - 2 SYNC: bits 3:0 select synchronous mode per channel; bits 11:8 enable broadcast per channel.
  - 3 CONFIG: storage only.
  - 4 GAIN: storage only.
  - 5 TRIGGER: bit 4 is soft-LDAC; writing 4'b1010 to bits 3:0 is a soft reset. Self-clearing, reads 0.
  - 6 BRDCAST.
  - 7 STATUS: reads 0.
  - 8–11: DAC buffers for channels 0–3.
  - 12–15 are reserved; writes are ignored and reads return 0.
- DAC buffer write (addr 8+n)
  - The value is loaded into buffer n.
  - If SYNC[n] = 0 (asynchronous), `vout`n is updated in the same commit.
  - If SYNC[n] = 1, `vout`n holds its value until an LDAC event.
- BRDCAST write: the data is loaded into every buffer n with SYNC[8+n] = 1. Each such channel then follows the same async/sync rule as a direct write.
- LDAC event: a synchronised `ldacn` rising edge, or a write of TRIGGER bit 4 = 1. On an LDAC event, every channel with SYNC[n] = 1 copies its buffer to `vout`n.
- Soft reset: all registers, buffers and outputs return to their reset values.
- Readback
  - A committed read frame latches {1'b1, 3'b0, addr, reg[addr]}. DAC addresses return the buffer value.
  - The latched word is shifted out on `sdo` during the next frame, MSB first. Each bit changes on an `sclk` rising edge; the first bit is valid after the `csn` falling edge.
  - `sdo` is 0 while `csn` is high or when no read is pending.
- Reset values: all buffers, outputs, SYNC, CONFIG, GAIN and the shift state are 0, and `sdo` = 0.

## Timing
- Input latency: 2 `clk` for synchronisation plus 1 `clk` for edge detection.
- Commit latency: `vout` updates from a commit become visible ≤ 4 `clk` after the `csn` rising edge.
- LDAC latency: `vout` updates from an LDAC event become visible ≤ 4 `clk` after the `ldacn` rising edge.
- `csn` and `ldacn` rising edges detected in the same `clk`: the commit is applied first, and the LDAC transfer sees the newly written buffer.
- `ldacn` is level-insensitive:
  - Holding `ldacn` low never updates outputs.
  - An `ldacn` rising edge in the middle of a frame transfers the buffers as they were before that frame.
- `csn` rising with `sclk` still high: the frame is committed normally.
- Extra bits beyond 24: only the last 24 count.
- Reset during a frame aborts it. The frame is ignored until the next `csn` falling edge.

## Test plan
- Async write
  - Setup: `ldacn` = 1, SYNC = 16'h000E.
  - Stimulus: write {0, 000, 1000, 16'hBEEF}.
  - Required: `vout0` = 0 before `csn` rises, and 16'hBEEF within 4 `clk` after.
- Sync write
  - Setup: `ldacn` = 0.
  - Stimulus: write 16'hCAFE to addr 10, raise `csn`, then raise `ldacn`.
  - Required: `vout2` stays 0 after the `csn` rise, and is 16'hCAFE within 4 `clk` of the `ldacn` rise.
- Short frame
  - Stimulus: a 20-bit frame to addr 9.
  - Required: no change to the buffer or to `vout1`.
- Broadcast
  - Setup: SYNC = 16'h0F00.
  - Stimulus: BRDCAST 16'h1234.
  - Required: all four outputs = 16'h1234.
- Readback
  - Stimulus: read frame for addr 1, followed by a NOP frame.
  - Required: `sdo` shifts out {1, 000, 0001, DEVICE_ID}.
- Reset
  - Stimulus: `rst_n` low mid-frame.
  - Required: all outputs = 0 and SYNC = 0. A complete frame issued afterwards works normally.
